// File: rtl/garuda_dot_sequencer.sv
// garuda_dot_sequencer
//   Drives the multi-lane int8 MAC wrapper for one long dot-product command.
//   Operand pairs are loaded NUM_LANES at a time. A partial last chunk is padded
//   with zero lanes. One exec then fires the lanes, and the result is carried
//   forward as the next chunk's rd.
//   Optional watchdog: define GARUDA_DOTSEQ_TIMEOUT_EN to abort a WAIT that never
//   sees mac_valid_i within TIMEOUT_CYCLES cycles.
//   Handshakes: a transfer happens on a rising clock edge where valid and ready are
//   both high. Valid never depends on ready. cmd/op/res all follow this rule.
module garuda_dot_sequencer #(
    parameter int NUM_LANES    = 16,
    parameter int XLEN         = 32,
    parameter int LEN_W        = 16,
    parameter int OPC_SIMD_DOT = 5
`ifdef GARUDA_DOTSEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 64
`endif
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         cmd_valid_i,
    output logic                         cmd_ready_o,
    input  logic [LEN_W-1:0]             cmd_len_i,
    input  logic [XLEN-1:0]              cmd_acc_init_i,
    input  logic                         op_valid_i,
    output logic                         op_ready_o,
    input  logic [31:0]                  op_a_i,
    input  logic [31:0]                  op_b_i,
    output logic                         mac_valid_o,
    output logic                         mac_lane_load_o,
    output logic                         mac_lane_exec_o,
    output logic [$clog2(NUM_LANES)-1:0] mac_lane_idx_o,
    output logic [4:0]                   mac_opcode_o,
    output logic [31:0]                  mac_rs1_o,
    output logic [31:0]                  mac_rs2_o,
    output logic [XLEN-1:0]              mac_rd_o,
    input  logic                         mac_valid_i,
    input  logic [XLEN-1:0]              mac_result_i,
    input  logic                         mac_overflow_i,
    output logic                         res_valid_o,
    input  logic                         res_ready_i,
    output logic [XLEN-1:0]              res_data_o,
    output logic                         res_overflow_o,
    output logic                         res_error_o,
    output logic                         busy_o,
    output logic [2:0]                   dbg_state_o
);
    localparam int LANE_W = $clog2(NUM_LANES);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_ZFILL = 3'd2;
    localparam logic [2:0] S_EXEC  = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic [XLEN-1:0]  r_acc;
    logic [LEN_W-1:0] r_remaining;
    logic [LANE_W-1:0] r_lane;
    logic             r_ovf;
    logic             w_op_fire;
    logic             w_last_lane;
    logic             w_last_word;
    logic             w_timeout;

    assign w_op_fire   = (r_state == S_LOAD) && op_valid_i;
    assign w_last_lane = (r_lane == {LANE_W{1'b1}});
    assign w_last_word = (r_remaining == LEN_W'(1));

`ifdef GARUDA_DOTSEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] r_wait_cnt;
    logic            r_err;

    // Watchdog: count consecutive WAIT cycles, restart whenever WAIT is left
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)               r_wait_cnt <= '0;
        else if (r_state == S_WAIT) r_wait_cnt <= r_wait_cnt + TO_W'(1);
        else                       r_wait_cnt <= '0;
    end

    assign w_timeout = (r_state == S_WAIT) && !mac_valid_i &&
                       (r_wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Error flag: set by a watchdog abort, cleared when a new command is taken
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                                r_err <= 1'b0;
        else if (r_state == S_IDLE && cmd_valid_i)  r_err <= 1'b0;
        else if (w_timeout)                         r_err <= 1'b1;
    end

    assign res_error_o = (r_state == S_DONE) && r_err;
`else
    assign w_timeout   = 1'b0;
    assign res_error_o = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (cmd_valid_i) w_next = (cmd_len_i == '0) ? S_DONE : S_LOAD;
            S_LOAD:  if (op_valid_i) begin
                         if (w_last_lane)      w_next = S_EXEC;
                         else if (w_last_word) w_next = S_ZFILL;
                     end
            S_ZFILL: if (w_last_lane) w_next = S_EXEC;
            S_EXEC:  w_next = S_WAIT;
            S_WAIT:  if (mac_valid_i)    w_next = (r_remaining != '0) ? S_LOAD : S_DONE;
                     else if (w_timeout) w_next = S_DONE;
            S_DONE:  if (res_ready_i) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: accumulator, word countdown, lane pointer, sticky overflow
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_acc       <= '0;
            r_remaining <= '0;
            r_lane      <= '0;
            r_ovf       <= 1'b0;
        end else begin
            if (r_state == S_IDLE && cmd_valid_i) begin
                r_acc       <= cmd_acc_init_i;
                r_remaining <= cmd_len_i;
                r_lane      <= '0;
                r_ovf       <= 1'b0;
            end
            if (w_op_fire) begin
                r_lane      <= r_lane + LANE_W'(1);
                r_remaining <= r_remaining - LEN_W'(1);
            end
            if (r_state == S_ZFILL) r_lane <= r_lane + LANE_W'(1);
            if (r_state == S_EXEC)  r_lane <= '0;
            if (r_state == S_WAIT && mac_valid_i) begin
                r_acc <= mac_result_i;
                r_ovf <= r_ovf | mac_overflow_i;
            end
        end
    end

    // Output decode from state (plus the operand handshake during LOAD)
    always_comb begin
        cmd_ready_o     = 1'b0;
        op_ready_o      = 1'b0;
        mac_valid_o     = 1'b0;
        mac_lane_load_o = 1'b0;
        mac_lane_exec_o = 1'b0;
        mac_lane_idx_o  = '0;
        mac_rs1_o       = '0;
        mac_rs2_o       = '0;
        mac_rd_o        = '0;
        res_valid_o     = 1'b0;
        res_data_o      = '0;
        res_overflow_o  = 1'b0;
        case (r_state)
            S_IDLE: cmd_ready_o = 1'b1;
            S_LOAD: begin
                op_ready_o = 1'b1;
                if (op_valid_i) begin
                    mac_valid_o     = 1'b1;
                    mac_lane_load_o = 1'b1;
                    mac_lane_idx_o  = r_lane;
                    mac_rs1_o       = op_a_i;
                    mac_rs2_o       = op_b_i;
                end
            end
            S_ZFILL: begin
                mac_valid_o     = 1'b1;
                mac_lane_load_o = 1'b1;
                mac_lane_idx_o  = r_lane;
            end
            S_EXEC: begin
                mac_valid_o     = 1'b1;
                mac_lane_exec_o = 1'b1;
                mac_rd_o        = r_acc;
            end
            S_DONE: begin
                res_valid_o    = 1'b1;
                res_data_o     = r_acc;
                res_overflow_o = r_ovf;
            end
            default: ;
        endcase
        mac_opcode_o = mac_valid_o ? 5'(OPC_SIMD_DOT) : 5'd0;
    end

    assign busy_o      = (r_state != S_IDLE);
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_garuda_dot_sequencer.sv
// Directed bench for garuda_dot_sequencer with a 2-cycle behavioural MAC stub.
module tb_garuda_dot_sequencer;
  localparam int NL = 16;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        cmd_valid_i = 0, cmd_ready_o;
  logic [15:0] cmd_len_i = 0;
  logic [31:0] cmd_acc_init_i = 0;
  logic        op_valid_i = 0, op_ready_o;
  logic [31:0] op_a_i = 0, op_b_i = 0;
  logic        mac_valid_o, mac_lane_load_o, mac_lane_exec_o;
  logic [3:0]  mac_lane_idx_o;
  logic [4:0]  mac_opcode_o;
  logic [31:0] mac_rs1_o, mac_rs2_o, mac_rd_o;
  logic        mac_valid_i;
  logic [31:0] mac_result_i;
  logic        mac_overflow_i;
  logic        res_valid_o, res_ready_i = 0;
  logic [31:0] res_data_o;
  logic        res_overflow_o, res_error_o, busy_o;
  logic [2:0]  dbg_state_o;

  int n_checks = 0;
  int n_fail = 0;

  garuda_dot_sequencer dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_len_i(cmd_len_i), .cmd_acc_init_i(cmd_acc_init_i),
    .op_valid_i(op_valid_i), .op_ready_o(op_ready_o),
    .op_a_i(op_a_i), .op_b_i(op_b_i),
    .mac_valid_o(mac_valid_o), .mac_lane_load_o(mac_lane_load_o),
    .mac_lane_exec_o(mac_lane_exec_o), .mac_lane_idx_o(mac_lane_idx_o),
    .mac_opcode_o(mac_opcode_o), .mac_rs1_o(mac_rs1_o), .mac_rs2_o(mac_rs2_o),
    .mac_rd_o(mac_rd_o), .mac_valid_i(mac_valid_i), .mac_result_i(mac_result_i),
    .mac_overflow_i(mac_overflow_i), .res_valid_o(res_valid_o),
    .res_ready_i(res_ready_i), .res_data_o(res_data_o),
    .res_overflow_o(res_overflow_o), .res_error_o(res_error_o),
    .busy_o(busy_o), .dbg_state_o(dbg_state_o)
  );

  // ---------------- MAC stub ----------------
  logic [31:0] st_a [NL];
  logic [31:0] st_b [NL];
  logic        s1_v, s1_o;
  logic [31:0] s1_d;
  int          exec_base = 0;
  int          ovf_chunk = -1;
  bit          stub_mute = 0;

  // monitor totals (written only by the monitor, with <=)
  int tot_load = 0, tot_zfill = 0, tot_exec = 0, tot_mvalid = 0, tot_opc_bad = 0;
  logic [31:0] last_rd = 0;
  int b_load, b_zfill, b_exec, b_mvalid;

  function automatic logic [31:0] lanes_sum(input logic [31:0] rd);
    int s;
    logic signed [7:0] x, y;
    s = int'(rd);
    for (int l = 0; l < NL; l++)
      for (int k = 0; k < 4; k++) begin
        x = st_a[l][8*k +: 8];
        y = st_b[l][8*k +: 8];
        s = s + int'(x) * int'(y);
      end
    return 32'(s);
  endfunction

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_v <= 0; s1_o <= 0; s1_d <= 0;
      mac_valid_i <= 0; mac_result_i <= 0; mac_overflow_i <= 0;
    end else begin
      mac_valid_i    <= s1_v;
      mac_result_i   <= s1_d;
      mac_overflow_i <= s1_o;
      s1_v <= 0;
      if (mac_valid_o && mac_lane_load_o) begin
        st_a[mac_lane_idx_o] <= mac_rs1_o;
        st_b[mac_lane_idx_o] <= mac_rs2_o;
      end
      if (mac_valid_o && mac_lane_exec_o && !stub_mute) begin
        s1_v <= 1;
        s1_d <= lanes_sum(mac_rd_o);
        s1_o <= ((tot_exec - exec_base) == ovf_chunk);
      end
    end
  end

  always @(posedge clk_i) begin
    if (mac_valid_o) tot_mvalid <= tot_mvalid + 1;
    if (mac_opcode_o !== (mac_valid_o ? 5'd5 : 5'd0)) tot_opc_bad <= tot_opc_bad + 1;
    if (mac_valid_o && mac_lane_load_o) begin
      if (mac_rs1_o == 0 && mac_rs2_o == 0) tot_zfill <= tot_zfill + 1;
      else tot_load <= tot_load + 1;
    end
    if (mac_valid_o && mac_lane_exec_o) begin
      tot_exec <= tot_exec + 1;
      last_rd  <= mac_rd_o;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic feed(input int len, input logic [31:0] a, input logic [31:0] b,
                      input bit gaps, output bit to);
    int i = 0;
    int cyc = 0;
    while (i < len && cyc < 2000) begin
      @(negedge clk_i); cyc++;
      if (gaps && $urandom_range(0, 2) == 0) op_valid_i = 0;
      else begin
        op_valid_i = 1; op_a_i = a; op_b_i = b;
        #1;
        if (op_ready_o) i++;
      end
    end
    if (len > 0) begin
      @(negedge clk_i);
      op_valid_i = 0;
    end
    to = (i < len);
  endtask

  task automatic do_cmd(input int len, input logic [31:0] acc, input logic [31:0] a,
                        input logic [31:0] b, input bit gaps, input int hold,
                        output logic [31:0] res, output logic ovf, output logic err,
                        output int lat, output bit to, output bit unstable, output bit rdy_leak);
    bit fto;
    exec_base = tot_exec;
    b_load = tot_load; b_zfill = tot_zfill; b_exec = tot_exec; b_mvalid = tot_mvalid;
    @(negedge clk_i);
    cmd_valid_i = 1; cmd_len_i = 16'(len); cmd_acc_init_i = acc;
    @(negedge clk_i);
    cmd_valid_i = 0;
    feed(len, a, b, gaps, fto);
    lat = 0;
    while (!res_valid_o && lat < 400) begin
      @(negedge clk_i); lat++;
    end
    to = fto || !res_valid_o;
    res = res_data_o; ovf = res_overflow_o; err = res_error_o;
    unstable = 0; rdy_leak = 0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk_i);
      if (res_data_o !== res || res_valid_o !== 1'b1) unstable = 1;
      if (cmd_ready_o !== 1'b0) rdy_leak = 1;
    end
    res_ready_i = 1;
    @(negedge clk_i);
    res_ready_i = 0;
  endtask

  logic [31:0] r_res;
  logic        r_ovf, r_err;
  int          r_lat;
  bit          r_to, r_unst, r_leak;

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    rst_ni = 0;
    #1;
    n_checks++;
    if ({cmd_ready_o, op_ready_o, mac_valid_o, mac_lane_load_o, mac_lane_exec_o,
         res_valid_o, res_overflow_o, res_error_o, busy_o} !== 9'b1_0000_0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected %b", {cmd_ready_o, op_ready_o, mac_valid_o,
               mac_lane_load_o, mac_lane_exec_o, res_valid_o, res_overflow_o, res_error_o,
               busy_o}, 9'b1_0000_0000);
    end
    n_checks++;
    if ({mac_opcode_o, mac_rd_o, res_data_o, mac_rs1_o, dbg_state_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: opc=%0d rd=%0d res=%0d rs1=%0d st=%0d expected all 0",
               mac_opcode_o, mac_rd_o, res_data_o, mac_rs1_o, dbg_state_o);
    end
    @(negedge clk_i);
    rst_ni = 1;
    @(negedge clk_i);
  endtask

  task automatic test_len1();
    do_cmd(1, 0, 32'h01020304, 32'h05060708, 0, 0, r_res, r_ovf, r_err, r_lat, r_to, r_unst, r_leak);
    n_checks++;
    if (r_to || r_res !== 32'd70) begin
      n_fail++; $display("FAIL len1_res: got %0d (timeout %0d) expected 70", r_res, r_to);
    end
    n_checks++;
    if ((tot_load - b_load) != 1 || (tot_zfill - b_zfill) != 15 || (tot_exec - b_exec) != 1) begin
      n_fail++;
      $display("FAIL len1_strobes: got load=%0d zfill=%0d exec=%0d expected 1/15/1",
               tot_load - b_load, tot_zfill - b_zfill, tot_exec - b_exec);
    end
    n_checks++;
    if (r_ovf !== 1'b0 || r_err !== 1'b0) begin
      n_fail++; $display("FAIL len1_flags: got ovf=%b err=%b expected 0/0", r_ovf, r_err);
    end
  endtask

  task automatic test_full_chunk();
    do_cmd(16, 10, 32'h01010101, 32'h02020202, 0, 0, r_res, r_ovf, r_err, r_lat, r_to, r_unst, r_leak);
    n_checks++;
    if (r_to || r_res !== 32'd138) begin
      n_fail++; $display("FAIL full_res: got %0d (timeout %0d) expected 138", r_res, r_to);
    end
    n_checks++;
    if ((tot_load - b_load) != 16 || (tot_zfill - b_zfill) != 0 || (tot_exec - b_exec) != 1) begin
      n_fail++;
      $display("FAIL full_strobes: got load=%0d zfill=%0d exec=%0d expected 16/0/1",
               tot_load - b_load, tot_zfill - b_zfill, tot_exec - b_exec);
    end
  endtask

  task automatic test_two_chunks();
    do_cmd(20, 0, 32'h01010101, 32'h02020202, 0, 0, r_res, r_ovf, r_err, r_lat, r_to, r_unst, r_leak);
    n_checks++;
    if (r_to || r_res !== 32'd160) begin
      n_fail++; $display("FAIL two_res: got %0d (timeout %0d) expected 160", r_res, r_to);
    end
    n_checks++;
    if ((tot_exec - b_exec) != 2 || (tot_zfill - b_zfill) != 12 || (tot_load - b_load) != 20) begin
      n_fail++;
      $display("FAIL two_strobes: got load=%0d zfill=%0d exec=%0d expected 20/12/2",
               tot_load - b_load, tot_zfill - b_zfill, tot_exec - b_exec);
    end
    n_checks++;
    if (last_rd !== 32'd128) begin
      n_fail++; $display("FAIL two_rd: got %0d expected 128", last_rd);
    end
  endtask

  task automatic test_len0();
    do_cmd(0, 7, 0, 0, 0, 0, r_res, r_ovf, r_err, r_lat, r_to, r_unst, r_leak);
    n_checks++;
    if (r_to || r_res !== 32'd7 || r_lat > 1) begin
      n_fail++; $display("FAIL len0_res: got %0d lat=%0d expected 7 lat<=1", r_res, r_lat);
    end
    n_checks++;
    if ((tot_mvalid - b_mvalid) != 0) begin
      n_fail++; $display("FAIL len0_mac: got %0d mac strobes expected 0", tot_mvalid - b_mvalid);
    end
  endtask

  task automatic test_backpressure();
    do_cmd(20, 0, 32'h01010101, 32'h02020202, 1, 5, r_res, r_ovf, r_err, r_lat, r_to, r_unst, r_leak);
    n_checks++;
    if (r_to || r_res !== 32'd160) begin
      n_fail++; $display("FAIL bp_res: got %0d (timeout %0d) expected 160", r_res, r_to);
    end
    n_checks++;
    if (r_unst || r_leak) begin
      n_fail++; $display("FAIL bp_hold: got unstable=%0d cmd_ready_leak=%0d expected 0/0", r_unst, r_leak);
    end
    n_checks++;
    if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL bp_idle: got cmd_ready=%b busy=%b expected 1/0", cmd_ready_o, busy_o);
    end
  endtask

  task automatic test_overflow();
    ovf_chunk = 0;
    do_cmd(20, 0, 32'h01010101, 32'h02020202, 0, 0, r_res, r_ovf, r_err, r_lat, r_to, r_unst, r_leak);
    ovf_chunk = -1;
    n_checks++;
    if (r_ovf !== 1'b1 || r_res !== 32'd160) begin
      n_fail++; $display("FAIL ovf_set: got ovf=%b res=%0d expected 1/160", r_ovf, r_res);
    end
    do_cmd(1, 0, 32'h01020304, 32'h05060708, 0, 0, r_res, r_ovf, r_err, r_lat, r_to, r_unst, r_leak);
    n_checks++;
    if (r_ovf !== 1'b0 || r_res !== 32'd70) begin
      n_fail++; $display("FAIL ovf_clear: got ovf=%b res=%0d expected 0/70", r_ovf, r_res);
    end
  endtask

`ifdef GARUDA_DOTSEQ_TIMEOUT_EN
  task automatic test_timeout();
    stub_mute = 1;
    do_cmd(16, 10, 32'h01010101, 32'h02020202, 0, 0, r_res, r_ovf, r_err, r_lat, r_to, r_unst, r_leak);
    stub_mute = 0;
    n_checks++;
    if (r_to || r_err !== 1'b1 || r_res !== 32'd10) begin
      n_fail++; $display("FAIL timeout: got to=%0d err=%b res=%0d expected 0/1/10", r_to, r_err, r_res);
    end
    do_cmd(1, 0, 32'h01020304, 32'h05060708, 0, 0, r_res, r_ovf, r_err, r_lat, r_to, r_unst, r_leak);
    n_checks++;
    if (r_err !== 1'b0 || r_res !== 32'd70) begin
      n_fail++; $display("FAIL timeout_clear: got err=%b res=%0d expected 0/70", r_err, r_res);
    end
  endtask
`endif

  task automatic test_reset_mid_load();
    @(negedge clk_i);
    cmd_valid_i = 1; cmd_len_i = 16; cmd_acc_init_i = 99;
    @(negedge clk_i);
    cmd_valid_i = 0; op_valid_i = 1; op_a_i = 32'h7f7f7f7f; op_b_i = 32'h7f7f7f7f;
    repeat (5) @(negedge clk_i);
    n_checks++;
    if (busy_o !== 1'b1 || mac_lane_load_o !== 1'b1) begin
      n_fail++; $display("FAIL midload_pre: got busy=%b load=%b expected 1/1", busy_o, mac_lane_load_o);
    end
    #2 rst_ni = 0;
    #1;
    n_checks++;
    if ({cmd_ready_o, op_ready_o, mac_valid_o, mac_lane_load_o, mac_lane_exec_o,
         res_valid_o, busy_o} !== 7'b1_000000) begin
      n_fail++;
      $display("FAIL midload_reset: got %b expected %b", {cmd_ready_o, op_ready_o, mac_valid_o,
               mac_lane_load_o, mac_lane_exec_o, res_valid_o, busy_o}, 7'b1_000000);
    end
    op_valid_i = 0;
    @(negedge clk_i);
    rst_ni = 1;
    @(negedge clk_i);
    // stale 0x7f lanes remain in the stub; zero-fill must hide them
    do_cmd(1, 0, 32'h01020304, 32'h05060708, 0, 0, r_res, r_ovf, r_err, r_lat, r_to, r_unst, r_leak);
    n_checks++;
    if (r_to || r_res !== 32'd70) begin
      n_fail++; $display("FAIL midload_after: got %0d expected 70", r_res);
    end
  endtask

  task automatic test_opcode();
    n_checks++;
    if (tot_opc_bad != 0) begin
      n_fail++; $display("FAIL opcode: got %0d bad cycles expected 0", tot_opc_bad);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    repeat (2) @(negedge clk_i);
    test_reset();
    test_len1();
    test_full_chunk();
    test_two_chunks();
    test_len0();
    test_backpressure();
    test_overflow();
`ifdef GARUDA_DOTSEQ_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_load();
    test_opcode();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
